// File: rtl/flash_reader_pkg.sv
// Shared constants and FSM state type for the SPI boot-flash reader.
// The FLASH_READER_FAST_READ_EN build selects CmdFastRead plus DummyCycles dummy clocks.
package flash_pkg;

    localparam logic [7:0] CmdRead     = 8'h03;
    localparam logic [7:0] CmdFastRead = 8'h0B;
    localparam int         DummyCycles = 8;

    typedef enum logic [2:0] {
        Idle,
        SendCommand,
        SendAddress,
        SendDummy,
        ReceiveData,
        Finish
    } state_e;

endpackage

// File: rtl/flash_reader_spi_clk_gen.sv
// SPI mode-0 clock generator: flash_clk idles low and toggles every HalfPeriod clk cycles.
// o_rise/o_fall mark the clk edge on which o_sck changes; i_stall holds o_sck low instead of rising.
module spi_clk_gen #(
    parameter int HalfPeriod = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_stall,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CntW    = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(HalfPeriod - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_sck;
    logic            w_term;

    assign w_term = (r_cnt == CntLast);
    assign o_rise = i_en && w_term && !r_sck && !i_stall;
    assign o_fall = i_en && w_term && r_sck;
    assign o_sck  = r_sck;

    // A stalled low phase parks the counter at its terminal value so the rise follows release at once.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (o_rise || o_fall) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else if (!w_term) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/flash_reader.sv
// Reads a byte stream from the SPI boot flash (READ 0x03) onto a ready/valid byte port.
// Define FLASH_READER_FAST_READ_EN to issue FAST_READ 0x0B with 8 dummy clocks instead.
module flash_reader
    import flash_pkg::*;
#(
    parameter int SckHalfPeriod = 2,
    parameter int LenBitWidth   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [23:0]            address,
    input  logic [LenBitWidth-1:0] length,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   flash_clk,
    output logic                   flash_mosi,
    input  logic                   flash_miso,
    output logic                   flash_cs
);

`ifdef FLASH_READER_FAST_READ_EN
    localparam logic [7:0] ReadCmd      = CmdFastRead;
    localparam state_e     AfterAddress = SendDummy;
`else
    localparam logic [7:0] ReadCmd      = CmdRead;
    localparam state_e     AfterAddress = ReceiveData;
`endif
    localparam logic [4:0] DummyLast = 5'(DummyCycles - 1);

    state_e                 r_state, w_next_state;
    logic [4:0]             r_bit_cnt;
    logic [31:0]            r_shift;
    logic [6:0]             r_rx;
    logic [LenBitWidth-1:0] r_bytes_left;
    logic                   r_cs, r_mosi, r_busy, r_done, r_out_valid;
    logic [7:0]             r_out_data;
    logic                   w_sck_en, w_stall, w_sck, w_rise, w_fall, w_last_fall;

    assign w_sck_en = (r_state inside {SendCommand, SendAddress, SendDummy, ReceiveData});
    // Hold flash_clk low before a new byte's first rise while the previous byte is still unaccepted.
    assign w_stall  = (r_state == ReceiveData) && (r_bit_cnt == 5'd0) && r_out_valid && !out_ready;
    assign w_last_fall = w_fall && (r_state == ReceiveData) && (r_bit_cnt == 5'd0)
                         && (r_bytes_left == '0);

    spi_clk_gen #(
        .HalfPeriod(SckHalfPeriod)
    ) u_clk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_sck_en),
        .i_stall(w_stall),
        .o_sck  (w_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= Idle;
        else        r_state <= w_next_state;
    end

    // NOTE: the default assignment first means no path leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            Idle:        if (start) w_next_state = (length == '0) ? Finish : SendCommand;
            SendCommand: if (w_fall && r_bit_cnt == 5'd7) w_next_state = SendAddress;
            SendAddress: if (w_fall && r_bit_cnt == 5'd31) w_next_state = AfterAddress;
            SendDummy:   if (w_fall && r_bit_cnt == DummyLast) w_next_state = ReceiveData;
            ReceiveData: if (w_last_fall) w_next_state = Finish;
            Finish:      w_next_state = Idle;
            default:     w_next_state = Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs         <= 1'b1;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx         <= '0;
            r_bytes_left <= '0;
        end else begin
            r_done <= (r_state == Finish);
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;

            case (r_state)
                Idle: begin
                    if (start) begin
                        r_bytes_left <= length;
                        if (length != '0) begin
                            r_cs      <= 1'b0;
                            r_busy    <= 1'b1;
                            r_mosi    <= ReadCmd[7];
                            r_shift   <= {ReadCmd[6:0], address, 1'b0};
                            r_bit_cnt <= '0;
                        end
                    end
                end
                // The zero padded into the shifter becomes mosi after the 32nd falling edge.
                SendCommand, SendAddress: begin
                    if (w_fall) begin
                        r_mosi    <= r_shift[31];
                        r_shift   <= {r_shift[30:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                SendDummy: begin
                    if (w_fall) r_bit_cnt <= (r_bit_cnt == DummyLast) ? '0 : r_bit_cnt + 5'd1;
                end
                ReceiveData: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[5:0], flash_miso};
                        if (r_bit_cnt == 5'd7) begin
                            r_out_data   <= {r_rx, flash_miso};
                            r_out_valid  <= 1'b1;
                            r_bytes_left <= r_bytes_left - LenBitWidth'(1);
                            r_bit_cnt    <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    if (w_last_fall) begin
                        r_cs   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign flash_clk  = w_sck;
    assign flash_mosi = r_mosi;
    assign flash_cs   = r_cs;

endmodule
